// File: rtl/lc3b_types.sv
// lc3b_types: shared word/line types and the pmem arbiter state encoding
package lc3b_types;
  typedef logic [15:0] lc3b_word;
  typedef logic [255:0] lc3b_line;
  typedef enum logic [1:0] {IDLE, L2_RD, VC_WR, BREAK} pmem_arb_state_t;
  localparam int DEFER_W = 4;
endpackage

// File: rtl/pmem_arbiter_if.sv
// pmem_arbiter_if: L2 fill, VC write-back and physical memory signals of the arbiter
interface pmem_arbiter_if;
  import lc3b_types::*;
  logic l2_read;
  lc3b_word l2_addr;
  lc3b_line l2_rdata;
  logic l2_resp;
  logic vc_write;
  lc3b_word vc_addr;
  lc3b_line vc_wdata;
  logic vc_resp;
  logic l2_pmem_busy;
  logic pmem_read;
  logic pmem_write;
  lc3b_word pmem_addr;
  lc3b_line pmem_wdata;
  lc3b_line pmem_rdata;
  logic pmem_resp;
  modport master (
    input l2_read, l2_addr, vc_write, vc_addr, vc_wdata, pmem_rdata, pmem_resp,
    output l2_rdata, l2_resp, vc_resp, l2_pmem_busy, pmem_read, pmem_write, pmem_addr, pmem_wdata
  );
  modport slave (
    output l2_read, l2_addr, vc_write, vc_addr, vc_wdata, pmem_rdata, pmem_resp,
    input l2_rdata, l2_resp, vc_resp, l2_pmem_busy, pmem_read, pmem_write, pmem_addr, pmem_wdata
  );
endinterface

// File: rtl/arb_defer_counter.sv
// arb_defer_counter: saturating count of L2 grants taken while a VC write-back waits
module arb_defer_counter
  import lc3b_types::*;
#(
  parameter int MAX_DEFER = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic clr_i,
  output logic limit_o
);
  localparam logic [DEFER_W-1:0] LIMIT = DEFER_W'(MAX_DEFER);
  logic [DEFER_W-1:0] cnt_q, cnt_d;
  // clear wins over increment; the count holds once it reaches the limit
  always_comb cnt_d = clr_i ? '0 : (inc_i && !limit_o) ? cnt_q + 1'b1 : cnt_q;
  // counter register
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign limit_o = cnt_q == LIMIT;
endmodule

// File: rtl/pmem_arbiter.sv
// pmem_arbiter: shares physical memory between L2 fills and victim-cache write-backs
module pmem_arbiter
  import lc3b_types::*;
#(
  parameter int MAX_DEFER = 4
) (
  input logic clk,
  input logic rst,
  pmem_arbiter_if.master bus
);
  pmem_arb_state_t state_q, state_d;
  lc3b_word addr_q, addr_d;
  lc3b_line wdata_q, wdata_d;
  logic grant_l2, grant_vc, at_limit, owned, l2_done;
  // arbitration in IDLE: a pending VC write jumps ahead when L2 has been favoured too often
  // or when L2 is about to refetch the very line the VC still holds dirty
  always_comb begin
    grant_vc = state_q == IDLE && bus.vc_write && (!bus.l2_read || at_limit || bus.l2_addr == bus.vc_addr);
    grant_l2 = state_q == IDLE && bus.l2_read && !grant_vc;
    owned = state_q == L2_RD || state_q == VC_WR;
    state_d = grant_vc ? VC_WR : grant_l2 ? L2_RD : (owned && bus.pmem_resp) ? BREAK : state_q == BREAK ? IDLE : state_q;
    addr_d = grant_vc ? bus.vc_addr : grant_l2 ? bus.l2_addr : addr_q;
    wdata_d = grant_vc ? bus.vc_wdata : wdata_q;
  end
  // state and captured request registers; pmem address/data stay stable for the whole transaction
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
    end
  arb_defer_counter #(.MAX_DEFER(MAX_DEFER)) u_defer (
    .clk(clk),
    .rst(rst),
    .inc_i(grant_l2 && bus.vc_write),
    .clr_i(grant_vc || !bus.vc_write),
    .limit_o(at_limit)
  );
  assign l2_done = state_q == L2_RD && bus.pmem_resp;
  assign bus.l2_resp = l2_done;
  assign bus.l2_rdata = l2_done ? bus.pmem_rdata : '0;
  assign bus.vc_resp = state_q == VC_WR && bus.pmem_resp;
  assign bus.l2_pmem_busy = bus.l2_read || state_q == L2_RD;
  assign bus.pmem_read = state_q == L2_RD;
  assign bus.pmem_write = state_q == VC_WR;
  assign bus.pmem_addr = addr_q;
  assign bus.pmem_wdata = wdata_q;
endmodule

// File: tb/tb_pmem_arbiter.sv
// tb_pmem_arbiter: directed scenarios plus randomized traffic against a transaction-level model
module tb_pmem_arbiter;
  localparam int MAXD = 4;
  logic clk = 0;
  logic rst = 1;
  int total = 0;
  int bad = 0;
  pmem_arbiter_if bus();
  pmem_arbiter #(.MAX_DEFER(MAXD)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.l2_read = 0;
    bus.l2_addr = 0;
    bus.vc_write = 0;
    bus.vc_addr = 0;
    bus.vc_wdata = 0;
    bus.pmem_resp = 0;
    bus.pmem_rdata = 0;
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  // memory responder: waits for a strobe, answers after lat extra cycles, returns at the following cycle
  task automatic serve(input int lat, input logic [255:0] d, output int kind, output logic [15:0] a,
                       output int waited, output logic l2r, output logic vcr, output logic [255:0] rd);
    kind = 0; a = 0; waited = 0; l2r = 0; vcr = 0; rd = 0;
    while (!(bus.pmem_read || bus.pmem_write) && waited < 20) begin
      tick();
      waited++;
    end
    if (!(bus.pmem_read || bus.pmem_write)) return;
    kind = bus.pmem_read ? 1 : 2;
    a = bus.pmem_addr;
    repeat (lat) tick();
    bus.pmem_resp = 1;
    bus.pmem_rdata = d;
    #1;
    l2r = bus.l2_resp;
    vcr = bus.vc_resp;
    rd = bus.l2_rdata;
    tick();
    bus.pmem_resp = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    bus.l2_read = 1;
    bus.pmem_resp = 1;
    #2;
    total++;
    if ({bus.pmem_read, bus.pmem_write, bus.l2_resp, bus.vc_resp} !== 4'b0000) begin
      bad++; $display("FAIL reset_strobes got=%b want=0000", {bus.pmem_read, bus.pmem_write, bus.l2_resp, bus.vc_resp});
    end
    total++;
    if (bus.pmem_addr !== 16'h0 || bus.pmem_wdata !== 256'h0 || bus.l2_rdata !== 256'h0) begin
      bad++; $display("FAIL reset_data addr=%h wdata=%h rdata=%h want all zero", bus.pmem_addr, bus.pmem_wdata, bus.l2_rdata);
    end
    total++;
    if (bus.l2_pmem_busy !== 1'b1) begin bad++; $display("FAIL reset_busy_hi got=%b want=1", bus.l2_pmem_busy); end
    bus.l2_read = 0;
    bus.pmem_resp = 0;
    #1;
    total++;
    if (bus.l2_pmem_busy !== 1'b0) begin bad++; $display("FAIL reset_busy_lo got=%b want=0", bus.l2_pmem_busy); end
    tick();
    rst = 0;
    tick();
  endtask

  task automatic test_l2_alone();
    logic [255:0] a5 = {32{8'hA5}};
    bus.l2_read = 1;
    bus.l2_addr = 16'h1240;
    #1;
    total++;
    if (bus.pmem_read !== 1'b0 || bus.l2_pmem_busy !== 1'b1) begin
      bad++; $display("FAIL l2_cycle0 read=%b busy=%b want read=0 busy=1", bus.pmem_read, bus.l2_pmem_busy);
    end
    tick();
    total++;
    if (bus.pmem_read !== 1'b1 || bus.pmem_write !== 1'b0 || bus.pmem_addr !== 16'h1240) begin
      bad++; $display("FAIL l2_cycle1 read=%b write=%b addr=%h want 1 0 1240", bus.pmem_read, bus.pmem_write, bus.pmem_addr);
    end
    tick();
    tick();
    total++;
    if (bus.pmem_read !== 1'b1 || bus.l2_resp !== 1'b0) begin
      bad++; $display("FAIL l2_cycle3 read=%b resp=%b want 1 0", bus.pmem_read, bus.l2_resp);
    end
    tick();
    bus.pmem_resp = 1;
    bus.pmem_rdata = a5;
    #1;
    total++;
    if (bus.l2_resp !== 1'b1 || bus.l2_rdata !== a5 || bus.vc_resp !== 1'b0) begin
      bad++; $display("FAIL l2_cycle4 resp=%b vc_resp=%b rdata=%h want 1 0 a5..", bus.l2_resp, bus.vc_resp, bus.l2_rdata);
    end
    tick();
    bus.l2_read = 0;
    #1;
    total++;
    if (bus.pmem_read !== 1'b0 || bus.l2_resp !== 1'b0 || bus.l2_rdata !== 256'h0) begin
      bad++; $display("FAIL l2_break read=%b resp=%b rdata=%h want 0 0 0", bus.pmem_read, bus.l2_resp, bus.l2_rdata);
    end
    tick();
    bus.pmem_resp = 0;
    tick();
  endtask

  task automatic test_vc_alone();
    logic [255:0] w = rand_line();
    bit busy_seen = 0;
    bus.vc_write = 1;
    bus.vc_addr = 16'h0380;
    bus.vc_wdata = w;
    #1 busy_seen |= bus.l2_pmem_busy;
    tick();
    busy_seen |= bus.l2_pmem_busy;
    total++;
    if (bus.pmem_write !== 1'b1 || bus.pmem_read !== 1'b0 || bus.pmem_addr !== 16'h0380 || bus.pmem_wdata !== w) begin
      bad++; $display("FAIL vc_strobe write=%b read=%b addr=%h wdata=%h want 1 0 0380 %h", bus.pmem_write, bus.pmem_read, bus.pmem_addr, bus.pmem_wdata, w);
    end
    tick();
    bus.pmem_resp = 1;
    #1;
    busy_seen |= bus.l2_pmem_busy;
    total++;
    if (bus.vc_resp !== 1'b1 || bus.l2_resp !== 1'b0 || bus.pmem_wdata !== w) begin
      bad++; $display("FAIL vc_resp vc=%b l2=%b want 1 0", bus.vc_resp, bus.l2_resp);
    end
    tick();
    bus.pmem_resp = 0;
    bus.vc_write = 0;
    #1;
    busy_seen |= bus.l2_pmem_busy;
    total++;
    if (bus.vc_resp !== 1'b0 || bus.pmem_write !== 1'b0) begin
      bad++; $display("FAIL vc_break vc_resp=%b write=%b want 0 0", bus.vc_resp, bus.pmem_write);
    end
    total++;
    if (busy_seen !== 1'b0) begin bad++; $display("FAIL vc_busy got=%b want=0", busy_seen); end
    tick();
  endtask

  task automatic test_simultaneous();
    int k, w;
    logic [15:0] a;
    logic l2r, vcr;
    logic [255:0] rd;
    logic [255:0] d = rand_line();
    bus.l2_read = 1; bus.l2_addr = 16'h1000;
    bus.vc_write = 1; bus.vc_addr = 16'h2000; bus.vc_wdata = rand_line();
    serve(1, d, k, a, w, l2r, vcr, rd);
    bus.l2_read = 0;
    total++;
    if (k !== 1 || a !== 16'h1000 || l2r !== 1'b1 || rd !== d) begin
      bad++; $display("FAIL sim_first kind=%0d addr=%h l2_resp=%b want 1 1000 1", k, a, l2r);
    end
    serve(1, d, k, a, w, l2r, vcr, rd);
    bus.vc_write = 0;
    total++;
    if (k !== 2 || a !== 16'h2000 || vcr !== 1'b1 || w !== 2) begin
      bad++; $display("FAIL sim_second kind=%0d addr=%h vc_resp=%b wait=%0d want 2 2000 1 2", k, a, vcr, w);
    end
    tick();
  endtask

  task automatic test_starvation();
    int k, w;
    logic [15:0] a;
    logic l2r, vcr;
    logic [255:0] rd;
    bus.l2_read = 1; bus.l2_addr = 16'h1000;
    bus.vc_write = 1; bus.vc_addr = 16'h2000; bus.vc_wdata = rand_line();
    for (int r = 0; r < 2; r++)
      for (int g = 0; g <= MAXD; g++) begin
        serve(0, rand_line(), k, a, w, l2r, vcr, rd);
        total++;
        if (k !== (g == MAXD ? 2 : 1)) begin
          bad++; $display("FAIL starve round=%0d grant=%0d kind=%0d want=%0d", r, g, k, g == MAXD ? 2 : 1);
        end
      end
    bus.l2_read = 0;
    bus.vc_write = 0;
    tick();
  endtask

  task automatic test_conflict();
    int k, w;
    logic [15:0] a;
    logic l2r, vcr;
    logic [255:0] rd;
    bus.l2_read = 1; bus.l2_addr = 16'h3340;
    bus.vc_write = 1; bus.vc_addr = 16'h3340; bus.vc_wdata = rand_line();
    serve(2, rand_line(), k, a, w, l2r, vcr, rd);
    bus.vc_write = 0;
    total++;
    if (k !== 2 || a !== 16'h3340 || vcr !== 1'b1) begin
      bad++; $display("FAIL conflict_first kind=%0d addr=%h vc_resp=%b want 2 3340 1", k, a, vcr);
    end
    serve(0, rand_line(), k, a, w, l2r, vcr, rd);
    bus.l2_read = 0;
    total++;
    if (k !== 1 || a !== 16'h3340 || l2r !== 1'b1) begin
      bad++; $display("FAIL conflict_second kind=%0d addr=%h l2_resp=%b want 1 3340 1", k, a, l2r);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int k, w;
    logic [15:0] a;
    logic l2r, vcr;
    logic [255:0] rd;
    logic [255:0] d = rand_line();
    bus.l2_read = 1;
    bus.l2_addr = 16'h0ABC;
    tick();
    total++;
    if (bus.pmem_read !== 1'b1) begin bad++; $display("FAIL rstmid_grant read=%b want=1", bus.pmem_read); end
    tick();
    rst = 1;
    bus.pmem_resp = 1;
    #1;
    total++;
    if (bus.pmem_read !== 1'b0 || bus.l2_resp !== 1'b0) begin
      bad++; $display("FAIL rstmid_drop read=%b resp=%b want 0 0", bus.pmem_read, bus.l2_resp);
    end
    tick();
    bus.pmem_resp = 0;
    rst = 0;
    tick();
    total++;
    if (bus.pmem_read !== 1'b1 || bus.pmem_addr !== 16'h0ABC) begin
      bad++; $display("FAIL rstmid_regrant read=%b addr=%h want 1 0abc", bus.pmem_read, bus.pmem_addr);
    end
    serve(1, d, k, a, w, l2r, vcr, rd);
    bus.l2_read = 0;
    total++;
    if (k !== 1 || l2r !== 1'b1 || rd !== d) begin
      bad++; $display("FAIL rstmid_finish kind=%0d l2_resp=%b want 1 1", k, l2r);
    end
    tick();
  endtask

  // model works per arbitration event: the port is either owned by one requester, in its
  // one-cycle cooldown after a completion, or free; fairness is a plain integer of deferrals
  task automatic test_random();
    int own = 0;
    bit cool = 0;
    int deferred = 0;
    logic [15:0] maddr = 0;
    logic [255:0] mwd = 0;
    int mwait = -1;
    bit l2_done = 0;
    bit vc_done = 0;
    int l2g = 0;
    int vcg = 0;
    bit el2, evc, win_vc, win_l2;
    logic [15:0] pool [4] = '{16'h1000, 16'h2000, 16'h3340, 16'h0380};
    for (int c = 0; c < 3000; c++) begin
      if (l2_done) bus.l2_read = 0;
      else if (!bus.l2_read && $urandom_range(0, 2) != 0) begin
        bus.l2_read = 1;
        bus.l2_addr = pool[$urandom_range(0, 3)];
      end
      if (vc_done) bus.vc_write = 0;
      else if (!bus.vc_write && $urandom_range(0, 3) == 0) begin
        bus.vc_write = 1;
        bus.vc_addr = pool[$urandom_range(0, 3)];
        bus.vc_wdata = rand_line();
      end
      if (bus.pmem_read || bus.pmem_write) begin
        if (mwait < 0) mwait = $urandom_range(0, 3);
        if (mwait == 0) begin bus.pmem_resp = 1; bus.pmem_rdata = rand_line(); mwait = -1; end
        else begin bus.pmem_resp = 0; mwait--; end
      end else begin
        mwait = -1;
        bus.pmem_resp = $urandom_range(0, 7) == 0;
        bus.pmem_rdata = rand_line();
      end
      #1;
      el2 = own == 1 && bus.pmem_resp;
      evc = own == 2 && bus.pmem_resp;
      total++;
      if ({bus.pmem_read, bus.pmem_write, bus.l2_resp, bus.vc_resp, bus.l2_pmem_busy} !== {own == 1, own == 2, el2, evc, bus.l2_read || own == 1}) begin
        bad++; $display("FAIL rand_ctrl cycle=%0d rd/wr/l2r/vcr/busy=%b want=%b", c,
          {bus.pmem_read, bus.pmem_write, bus.l2_resp, bus.vc_resp, bus.l2_pmem_busy}, {own == 1, own == 2, el2, evc, bus.l2_read || own == 1});
      end
      if (own != 0) begin
        total++;
        if (bus.pmem_addr !== maddr) begin bad++; $display("FAIL rand_addr cycle=%0d got=%h want=%h", c, bus.pmem_addr, maddr); end
      end
      if (own == 2) begin
        total++;
        if (bus.pmem_wdata !== mwd) begin bad++; $display("FAIL rand_wdata cycle=%0d got=%h want=%h", c, bus.pmem_wdata, mwd); end
      end
      total++;
      if (bus.l2_rdata !== (el2 ? bus.pmem_rdata : 256'h0)) begin
        bad++; $display("FAIL rand_rdata cycle=%0d got=%h", c, bus.l2_rdata);
      end
      l2_done = el2;
      vc_done = evc;
      win_vc = 0;
      win_l2 = 0;
      if (own != 0) begin
        if (bus.pmem_resp) begin own = 0; cool = 1; end
      end else if (cool) cool = 0;
      else if (bus.vc_write && (!bus.l2_read || deferred == MAXD || bus.l2_addr == bus.vc_addr)) win_vc = 1;
      else if (bus.l2_read) win_l2 = 1;
      if (win_vc) begin own = 2; maddr = bus.vc_addr; mwd = bus.vc_wdata; vcg++; end
      if (win_l2) begin own = 1; maddr = bus.l2_addr; l2g++; end
      if (!bus.vc_write || win_vc) deferred = 0;
      else if (win_l2 && deferred < MAXD) deferred++;
      tick();
    end
    total++;
    if (l2g == 0 || vcg == 0) begin bad++; $display("FAIL rand_coverage l2_grants=%0d vc_grants=%0d want both nonzero", l2g, vcg); end
    idle_inputs();
    tick();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_l2_alone();
    test_vc_alone();
    test_simultaneous();
    test_starvation();
    test_conflict();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end
endmodule
